// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

    // Frame sequencer states, in the order a frame walks through them.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rxState_e;

    // Oversampling ratios the receiver knows how to sample correctly.
    localparam int unsigned PRESCALE_8  = 8;
    localparam int unsigned PRESCALE_16 = 16;
    localparam int unsigned PRESCALE_32 = 32;

    // Data bits per frame; the parity checker is built for eight.
    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    // True when the requested oversampling ratio is one we support.
    function automatic logic isLegalPrescale(input int unsigned p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and data bit counter for the UART receiver,
// with the mid-bit sample-point and end-of-bit decodes.
module uart_rx_edge_bit_counter #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  run_i,
    input  logic                  bitAdvance_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  sample0_o,
    output logic                  sample1_o,
    output logic                  sample2_o,
    output logic                  bitEnd_o,
    output logic                  lastBit_o
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [PRESCALE_W-1:0] edgeCnt_q, edgeCnt_d;
    logic [BIT_W-1:0]      bitCnt_q, bitCnt_d;
    logic [PRESCALE_W-1:0] halfP;

    assign halfP     = {1'b0, prescale_i[PRESCALE_W-1:1]};
    assign sample0_o = (edgeCnt_q == halfP - PRESCALE_W'(1));
    assign sample1_o = (edgeCnt_q == halfP);
    assign sample2_o = (edgeCnt_q == halfP + PRESCALE_W'(1));
    assign bitEnd_o  = (edgeCnt_q == prescale_i - PRESCALE_W'(1));
    assign lastBit_o = (bitCnt_q == BIT_W'(DATA_WIDTH - 1));

    // Edge count wraps every bit period; bit count only advances in the data phase.
    always_comb begin
        edgeCnt_d = edgeCnt_q;
        bitCnt_d  = bitCnt_q;
        if (clear_i) begin
            edgeCnt_d = '0;
            bitCnt_d  = '0;
        end else if (run_i) begin
            edgeCnt_d = bitEnd_o ? '0 : edgeCnt_q + PRESCALE_W'(1);
            if (bitAdvance_i && bitEnd_o) begin
                bitCnt_d = lastBit_o ? '0 : bitCnt_q + BIT_W'(1);
            end
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            edgeCnt_q <= '0;
            bitCnt_q  <= '0;
        end else begin
            edgeCnt_q <= edgeCnt_d;
            bitCnt_q  <= bitCnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive frame sequencer: start detection, 2-of-3 mid-bit sampling,
// byte assembly, parity checker control and per-frame status pulses.
module uart_rx_controller
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  parity_error_in,
    output logic                  sampled_data,
    output logic                  sample_strobe,
    output logic                  parity_check_enable,
    output logic                  parity_type_o,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  framing_error,
    output logic                  start_glitch,
    output logic                  busy
);

    rxState_e state_q, state_d;

    logic [PRESCALE_W-1:0] prescale_q;
    logic [PRESCALE_W-1:0] presLegal;
    logic                  parEn_q;
    logic                  parTyp_q;
    logic                  parErr_q;
    logic                  sample0_q;
    logic                  sample1_q;
    logic                  sampledData_q;
    logic                  sampleStrobe_q;
    logic [DATA_WIDTH-1:0] shiftReg_q;
    logic [DATA_WIDTH-1:0] pData_q;
    logic                  dataValid_q;
    logic                  parityError_q;
    logic                  framingError_q;
    logic                  startGlitch_q;

    logic startDetect;
    logic glitchAbort;
    logic sample0, sample1, sample2;
    logic bitEnd, lastBit;
    logic majority;

    assign busy        = (state_q != IDLE);
    assign startDetect = (state_q == IDLE) && !rx_in;
    assign glitchAbort = (state_q == START) && sampleStrobe_q && sampledData_q;
    assign majority    = (sample0_q & sample1_q) | (sample0_q & rx_in) | (sample1_q & rx_in);
    assign presLegal   = isLegalPrescale(32'(prescale)) ? prescale : PRESCALE_W'(PRESCALE_8);

    assign sampled_data        = sampledData_q;
    assign sample_strobe       = sampleStrobe_q;
    assign parity_check_enable = parEn_q && ((state_q == DATA) || (state_q == PARITY));
    assign parity_type_o       = parTyp_q;
    assign p_data              = pData_q;
    assign data_valid          = dataValid_q;
    assign parity_error        = parityError_q;
    assign framing_error       = framingError_q;
    assign start_glitch        = startGlitch_q;

    uart_rx_edge_bit_counter #(
        .DATA_WIDTH (DATA_WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) uCounter (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (glitchAbort),
        .run_i        (busy || startDetect),
        .bitAdvance_i (state_q == DATA),
        .prescale_i   (prescale_q),
        .sample0_o    (sample0),
        .sample1_o    (sample1),
        .sample2_o    (sample2),
        .bitEnd_o     (bitEnd),
        .lastBit_o    (lastBit)
    );

    // Next-state logic: each phase ends on the last oversampling edge of its bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!rx_in) begin
                    state_d = START;
                end
            end
            START: begin
                if (glitchAbort) begin
                    state_d = IDLE;
                end else if (bitEnd) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bitEnd && lastBit) begin
                    state_d = parEn_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bitEnd) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bitEnd) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame datapath: config latch, majority sampler, shift register and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_q     <= PRESCALE_W'(PRESCALE_8);
            parEn_q        <= 1'b0;
            parTyp_q       <= 1'b0;
            parErr_q       <= 1'b0;
            sample0_q      <= 1'b0;
            sample1_q      <= 1'b0;
            sampledData_q  <= 1'b0;
            sampleStrobe_q <= 1'b0;
            shiftReg_q     <= '0;
            pData_q        <= '0;
            dataValid_q    <= 1'b0;
            parityError_q  <= 1'b0;
            framingError_q <= 1'b0;
            startGlitch_q  <= 1'b0;
        end else begin
            sampleStrobe_q <= 1'b0;
            dataValid_q    <= 1'b0;
            parityError_q  <= 1'b0;
            framingError_q <= 1'b0;
            startGlitch_q  <= 1'b0;

            if (startDetect) begin
                prescale_q <= presLegal;
                parEn_q    <= par_en;
                parTyp_q   <= par_typ;
                parErr_q   <= 1'b0;
            end

            if (busy) begin
                if (sample0) begin
                    sample0_q <= rx_in;
                end
                if (sample1) begin
                    sample1_q <= rx_in;
                end
                if (sample2) begin
                    sampledData_q  <= majority;
                    sampleStrobe_q <= 1'b1;
                end
            end

            if (glitchAbort) begin
                startGlitch_q <= 1'b1;
            end

            if ((state_q == DATA) && sampleStrobe_q) begin
                shiftReg_q <= {sampledData_q, shiftReg_q[DATA_WIDTH-1:1]};
            end

            if ((state_q == PARITY) && bitEnd) begin
                parErr_q <= parity_error_in;
            end

            if ((state_q == STOP) && sampleStrobe_q) begin
                if (!sampledData_q) begin
                    framingError_q <= 1'b1;
                end else if (parErr_q) begin
                    parityError_q <= 1'b1;
                end else begin
                    pData_q     <= shiftReg_q;
                    dataValid_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed testbench for uart_rx_controller: good frames, parity and framing
// errors, start glitch, back-to-back frames, mid-frame reset, illegal prescale.
module tb_uart_rx_controller;

    logic       clk;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic       parity_error_in;
    logic       sampled_data;
    logic       sample_strobe;
    logic       parity_check_enable;
    logic       parity_type_o;
    logic [7:0] p_data;
    logic       data_valid;
    logic       parity_error;
    logic       framing_error;
    logic       start_glitch;
    logic       busy;

    int checkCount = 0;
    int errorCount = 0;

    int dvCount  = 0;
    int peCount  = 0;
    int feCount  = 0;
    int sgCount  = 0;
    int pceCount = 0;
    logic [7:0] lastData = 8'h00;
    logic [7:0] prevData = 8'h00;

    int dv0, pe0, fe0, sg0, pce0;

    uart_rx_controller #(
        .DATA_WIDTH (8),
        .PRESCALE_W (6)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rx_in               (rx_in),
        .prescale            (prescale),
        .par_en              (par_en),
        .par_typ             (par_typ),
        .parity_error_in     (parity_error_in),
        .sampled_data        (sampled_data),
        .sample_strobe       (sample_strobe),
        .parity_check_enable (parity_check_enable),
        .parity_type_o       (parity_type_o),
        .p_data              (p_data),
        .data_valid          (data_valid),
        .parity_error        (parity_error),
        .framing_error       (framing_error),
        .start_glitch        (start_glitch),
        .busy                (busy)
    );

    // Free-running oversampling clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: counts status pulses and parity-enable cycles, keeps the last two bytes.
    always @(negedge clk) begin
        if (data_valid) begin
            dvCount  = dvCount + 1;
            prevData = lastData;
            lastData = p_data;
        end
        if (parity_error)        peCount  = peCount + 1;
        if (framing_error)       feCount  = feCount + 1;
        if (start_glitch)        sgCount  = sgCount + 1;
        if (parity_check_enable) pceCount = pceCount + 1;
    end

    // Compares one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount = checkCount + 1;
        if (obs !== exp) begin
            errorCount = errorCount + 1;
            $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Remembers the monitor counts so a test can look at its own deltas.
    task automatic takeSnapshot();
        dv0  = dvCount;
        pe0  = peCount;
        fe0  = feCount;
        sg0  = sgCount;
        pce0 = pceCount;
    endtask

    // Holds one line level for n clock edges; entered and left #1 after a posedge.
    task automatic driveBit(input logic v, input int n);
        rx_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends one frame: start, eight data bits LSB first, optional parity, stop.
    task automatic applyStimulus(input logic [7:0] data, input logic withParity,
                                 input logic parityBit, input logic parErrIn,
                                 input logic stopBit, input int p, input int stopCycles);
        driveBit(1'b0, p);
        for (int i = 0; i < 8; i++) begin
            driveBit(data[i], p);
        end
        if (withParity) begin
            parity_error_in = parErrIn;
            driveBit(parityBit, p);
            parity_error_in = 1'b0;
        end
        driveBit(stopBit, stopCycles);
        rx_in = 1'b1;
    endtask

    initial begin
        rst             = 1'b1;
        rx_in           = 1'b1;
        prescale        = 6'd8;
        par_en          = 1'b0;
        par_typ         = 1'b0;
        parity_error_in = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstBusy",   32'(busy), 0);
        checkOutput("rstPData",  32'(p_data), 0);
        checkOutput("rstStrobe", 32'(sample_strobe), 0);
        checkOutput("rstPce",    32'(parity_check_enable), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] test 1: good frame 0xA5, prescale 8, even parity");
        prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0;
        takeSnapshot();
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8, 7);
        checkOutput("t1BusyLastCycle", 32'(busy), 1);
        @(posedge clk);
        #1;
        checkOutput("t1BusyAfter88", 32'(busy), 0);
        checkOutput("t1DvCount",  32'(dvCount - dv0), 1);
        checkOutput("t1PData",    32'(p_data), 32'h A5);
        checkOutput("t1PeCount",  32'(peCount - pe0), 0);
        checkOutput("t1FeCount",  32'(feCount - fe0), 0);
        checkOutput("t1PceCycles", 32'(pceCount - pce0), 72);

        $display("[TB] test 2: parity error frame");
        takeSnapshot();
        applyStimulus(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 8, 8);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t2PeCount", 32'(peCount - pe0), 1);
        checkOutput("t2DvCount", 32'(dvCount - dv0), 0);
        checkOutput("t2PData",   32'(p_data), 32'h A5);

        $display("[TB] test 3: framing error, prescale 16, no parity");
        prescale = 6'd16; par_en = 1'b0;
        takeSnapshot();
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 16, 16);
        checkOutput("t3BusyAfter10", 32'(busy), 0);
        checkOutput("t3FeCount",  32'(feCount - fe0), 1);
        checkOutput("t3DvCount",  32'(dvCount - dv0), 0);
        checkOutput("t3PceCycles", 32'(pceCount - pce0), 0);

        $display("[TB] test 4: start glitch then good frame 0x55");
        prescale = 6'd8;
        repeat (2) @(posedge clk);
        #1;
        takeSnapshot();
        driveBit(1'b0, 2);
        rx_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t4Strobe",  32'(sample_strobe), 1);
        checkOutput("t4Sampled", 32'(sampled_data), 1);
        @(posedge clk);
        #1;
        checkOutput("t4Glitch",  32'(start_glitch), 1);
        checkOutput("t4Busy",    32'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 8, 8);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t4SgCount", 32'(sgCount - sg0), 1);
        checkOutput("t4FeCount", 32'(feCount - fe0), 0);
        checkOutput("t4DvCount", 32'(dvCount - dv0), 1);
        checkOutput("t4PData",   32'(p_data), 32'h 55);

        $display("[TB] test 5: back-to-back frames, prescale 32");
        prescale = 6'd32;
        takeSnapshot();
        applyStimulus(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 32, 32);
        applyStimulus(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 32, 32);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t5DvCount", 32'(dvCount - dv0), 2);
        checkOutput("t5First",   32'(prevData), 32'h 01);
        checkOutput("t5Second",  32'(lastData), 32'h FE);
        checkOutput("t5SgCount", 32'(sgCount - sg0), 0);

        $display("[TB] test 6: reset in data bit 4, then 0x81 with prescale 12");
        prescale = 6'd8; par_en = 1'b1; par_typ = 1'b1;
        takeSnapshot();
        driveBit(1'b0, 8);
        for (int i = 0; i < 4; i++) begin
            driveBit(1'b1, 8);
        end
        driveBit(1'b0, 4);
        checkOutput("t6BusyMid",  32'(busy), 1);
        checkOutput("t6ParTypMid", 32'(parity_type_o), 1);
        checkOutput("t6PceMid",   32'(parity_check_enable), 1);
        rst   = 1'b1;
        rx_in = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t6RstBusy",   32'(busy), 0);
        checkOutput("t6RstPData",  32'(p_data), 0);
        checkOutput("t6RstParTyp", 32'(parity_type_o), 0);
        checkOutput("t6RstPce",    32'(parity_check_enable), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t6NoPulses", 32'((dvCount - dv0) + (peCount - pe0) + (feCount - fe0) + (sgCount - sg0)), 0);
        prescale = 6'd12; par_en = 1'b0; par_typ = 1'b0;
        takeSnapshot();
        applyStimulus(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 8, 8);
        checkOutput("t6BusyEnd", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t6DvCount", 32'(dvCount - dv0), 1);
        checkOutput("t6PData",   32'(p_data), 32'h 81);
        checkOutput("t6FeCount", 32'(feCount - fe0), 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/uart_rx_controller.md
Name: uart_rx_controller

Overview:
Frame-level sequencer for the UART receiver. It runs on the oversampling clock and detects the start edge. It majority-samples each bit and steps through the start, data, parity and stop bits. It drives the parity checker's enable, bit stream and parity type, then assembles the received byte and reports data_valid, parity, framing and start-glitch status to the host side.

Parameters:
DATA_WIDTH, 8, data bits per frame, LSB first. Must be 8 when paired with parity_check.
PRESCALE_W, 6, width of the prescale input.

Ports:
clk  input  1  oversampling clock (prescale ticks per bit)
rst  input  1  synchronous, active-high reset
rx_in  input  1  serial line, idle high
prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32
par_en  input  1  1 = frame carries a parity bit
par_typ  input  1  0 = even, 1 = odd
parity_error_in  input  1  result from parity checker
sampled_data  output  1  majority-voted value of the current bit
sample_strobe  output  1  one-cycle pulse when sampled_data is updated
parity_check_enable  output  1  enable to parity checker
parity_type_o  output  1  par_typ latched for the current frame
p_data  output  DATA_WIDTH  last good byte
data_valid  output  1  one-cycle pulse, p_data updated
parity_error  output  1  one-cycle pulse, frame dropped
framing_error  output  1  one-cycle pulse, stop bit sampled 0
start_glitch  output  1  one-cycle pulse, false start
busy  output  1  high in any state except IDLE

Behaviour:
- Reset values: all outputs 0. State = IDLE. Counters and shift register = 0. Reset mid-frame aborts the frame with no status pulse.
- Config latch: prescale, par_en and par_typ are latched on start detection and held for the whole frame. An illegal prescale latches as 8.
- Internal counters:
  - edge_cnt runs 0..P-1 within each bit (P = latched prescale).
  - bit_cnt runs 0..DATA_WIDTH-1 in DATA.
- Bit sampling: rx_in is sampled at edge_cnt P/2-1, P/2 and P/2+1. The 2-of-3 majority is registered into sampled_data at edge_cnt P/2+2, with sample_strobe high for that one cycle.
- IDLE: when rx_in==0, go to START. That detection cycle is edge_cnt 0 and latches config.
- START:
  - At the sample strobe, if sampled_data==1: pulse start_glitch and go to IDLE on the next cycle.
  - Otherwise go to DATA at edge_cnt P-1.
- DATA:
  - Each strobe shifts sampled_data into the MSB of shift_reg (so the LSB lands at bit 0).
  - At edge_cnt P-1 with bit_cnt==DATA_WIDTH-1: go to PARITY if par_en, else STOP.
- PARITY: at edge_cnt P-1, capture parity_error_in into par_err_r, then go to STOP.
- parity_check_enable: high from DATA entry through the end of PARITY, only when par_en is latched. It drops low in STOP and IDLE, which also clears the checker.
- STOP: at the strobe, evaluate in this priority order:
  1. sampled_data==0: framing_error pulse.
  2. Else par_err_r: parity_error pulse.
  3. Else: p_data <= shift_reg and data_valid pulse.
  - Pulses occur the cycle after the strobe.
  - Exactly one status pulse is produced per non-glitch frame.
  - p_data holds its value until the next good frame.
- Frame end: STOP goes to IDLE at edge_cnt P-1. A start edge on the very next cycle is accepted, so back-to-back frames need no idle gap.
- rx_in changes while in START/DATA/PARITY/STOP are ignored except at the sample points.
- par_err_r is cleared on entry to START.
- busy = (state != IDLE).

Decomposition:
- Package uart_rx_pkg:
  - State encoding: IDLE, START, DATA, PARITY, STOP.
  - Legal prescale constants: 8, 16, 32.
  - Default DATA_WIDTH.
- One natural sub-module: uart_rx_edge_bit_counter, which holds edge_cnt and bit_cnt and produces the sample-point and end-of-bit decodes.
- The FSM and majority sampler stay in the top.

Test Plan:
1. prescale=8, par_en=1, par_typ=0, frame 0xA5 with parity 0 and stop 1 -> data_valid once, p_data=0xA5, parity_error=0, framing_error=0, busy low 11*8 cycles after the start edge.
2. Same frame with parity bit 1 and parity_error_in driven 1 at end of parity bit -> parity_error pulse, no data_valid, p_data unchanged.
3. prescale=16, par_en=0, byte 0x3C with stop bit 0 -> framing_error pulse, no data_valid, back in IDLE after 10 bits.
4. rx_in low for 2 cycles only (prescale=8) -> start_glitch pulse at strobe+1, IDLE, no other status; a following valid frame 0x55 is received correctly.
5. Two back-to-back frames 0x01 then 0xFE, prescale=32, no idle gap -> two data_valid pulses, p_data 0x01 then 0xFE.
6. Assert rst at DATA bit 4 -> all outputs 0 next cycle; a subsequent frame 0x81 is received correctly. Illegal prescale=12 behaves as 8.
